pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width.
REQ-002 SHALL have parameter BR_STAGE, default 2; 2 = branch resolved in EX, 3 = in MEM; other values illegal.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2, id_rd  input  RA_W each  ID source and destination register addresses.
REQ-008 id_rs1_used, id_rs2_used  input  1 each  the ID instruction reads that source.
REQ-009 id_regwrite, id_memread  input  1 each  ID control bits.
REQ-010 br_taken  input  1  taken branch at stage BR_STAGE; ignored unless that stage's record is valid.
REQ-011 pc_stall, ifid_stall, idex_bubble  output  1 each  load-use interlock controls.
REQ-012 ifid_flush, idex_flush, exmem_flush  output  1 each  squash controls.
REQ-013 fwd_a, fwd_b  output  2 each  EX operand source: 00 = regfile, 10 = MEM result, 01 = WB result.
REQ-014 ex_valid, mem_valid, wb_valid  output  1 each  stage-record valid bits.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 SHALL keep EX, MEM and WB records of {valid, rd, rs1, rs2, regwrite, memread}, advancing ID->EX->MEM->WB every cycle (no global freeze).
REQ-017 SHALL raise load_use combinationally when id_valid, ex.valid, ex.memread and ex.rd != 0 hold, and ex.rd equals id_rs1 with id_rs1_used or id_rs2 with id_rs2_used.
REQ-018 On load_use without taken flush, SHALL assert pc_stall, ifid_stall and idex_bubble for exactly that cycle; the next EX record SHALL be loaded invalid.
REQ-019 Taken flush SHALL be br_taken while the BR_STAGE record is valid (EX record for 2, MEM record for 3).
REQ-020 For BR_STAGE=2, a taken flush SHALL assert ifid_flush and idex_flush; exmem_flush SHALL stay 0.
REQ-021 For BR_STAGE=3, a taken flush SHALL assert all three flush outputs.
REQ-022 A flushed stage SHALL load an invalid record on the next edge.
REQ-023 When a taken flush and load_use coincide, the flush SHALL win and all stall/bubble outputs SHALL be 0.
REQ-024 fwd_a SHALL be 10 when mem.valid, mem.regwrite, mem.rd != 0 and mem.rd == ex.rs1; else 01 under the same test on wb; else 00. MEM has priority. fwd_b SHALL do the same for ex.rs2.
REQ-025 fwd_a and fwd_b SHALL be 00 when ex.valid = 0.
REQ-026 All control outputs SHALL be combinational from records and current inputs (zero latency); records and counters SHALL be registered.
REQ-027 stall_cnt SHALL increment once per cycle with pc_stall = 1; flush_cnt SHALL increment once per taken flush; both SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-028 While rst = 0, SHALL clear all valid bits, rd/rs fields and counters to 0, making every output 0 regardless of inputs.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort it immediately; the first post-reset cycle SHALL behave as an empty pipeline.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the fwd encodings (FWD_RF, FWD_MEM, FWD_WB), the BR_STAGE values (BR_EX, BR_MEM) and the stage-record struct.
REQ-031 One sub-module fwd_sel (single-operand forwarding compare) SHALL be instantiated twice, once per operand.

Verification
REQ-032 lw x5 followed by add x6,x5,x1 -> one cycle of pc_stall/ifid_stall/idex_bubble = 1; two cycles later fwd_a = 01; stall_cnt = 1.
REQ-033 add x3 then sub x4,x3,x3 back-to-back -> fwd_a = fwd_b = 10 in the sub's EX cycle; x3 written by both MEM and WB -> 10 selected.
REQ-034 Writes to x0 followed by a reader of x0 -> fwd = 00, no stall.
REQ-035 BR_STAGE=3, taken branch in MEM while ID has a load-use hit -> all three flushes = 1, stalls = 0, three invalid records follow, flush_cnt = 1.
REQ-036 CNT_W=2, four load-use stalls -> stall_cnt reads 1, 2, 3, 3.
REQ-037 rst low during a stall cycle -> outputs 0 at once; after release, id_valid = 0 -> ex_valid = 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding encodings,
// branch-resolution stage identifiers and the per-stage instruction record.
package pipe_pkg;

  // Record address fields are sized to hold any supported RA_W (up to 8 bits)
  localparam int REC_RA_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

  typedef struct packed {
    logic                valid;
    logic [REC_RA_W-1:0] rd;
    logic [REC_RA_W-1:0] rs1;
    logic [REC_RA_W-1:0] rs2;
    logic                regwrite;
    logic                memread;
  } stage_rec_t;

  // True when a record will write a non-zero register that matches src
  function automatic logic rec_writes(input stage_rec_t rec, input logic [REC_RA_W-1:0] src);
    return rec.valid && rec.regwrite && (rec.rd != {REC_RA_W{1'b0}}) && (rec.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source select for one EX operand; the MEM result is newer than
// the WB result, so it takes priority.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic                ex_valid,
  input  logic [REC_RA_W-1:0] src,
  input  stage_rec_t          mem_rec,
  input  stage_rec_t          wb_rec,
  output logic [1:0]          fwd
);

  logic unused_fields_s;
  assign unused_fields_s = ^{mem_rec.rs1, mem_rec.rs2, mem_rec.memread,
                             wb_rec.rs1, wb_rec.rs2, wb_rec.memread};

  // Operand source priority: MEM, then WB, else register file
  always_comb begin
    fwd = FWD_RF;
    if (!ex_valid) begin
      fwd = FWD_RF;
    end else if (rec_writes(mem_rec, src)) begin
      fwd = FWD_MEM;
    end else if (rec_writes(wb_rec, src)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use interlock, branch squash,
// operand forwarding and saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_rec_t          ex_r, mem_r, wb_r;
  stage_rec_t          ex_next_s, mem_next_s;
  logic [REC_RA_W-1:0] id_rs1_s, id_rs2_s, id_rd_s;
  logic                load_use_s, br_rec_valid_s, taken_s;
  logic [CNT_W-1:0]    stall_cnt_r, flush_cnt_r;

  assign id_rs1_s = REC_RA_W'(id_rs1);
  assign id_rs2_s = REC_RA_W'(id_rs2);
  assign id_rd_s  = REC_RA_W'(id_rd);

  // Hazard detection and interlock/squash controls; a taken branch overrides the stall
  always_comb begin
    load_use_s = id_valid && ex_r.valid && ex_r.memread && (ex_r.rd != {REC_RA_W{1'b0}}) &&
                 (((ex_r.rd == id_rs1_s) && id_rs1_used) || ((ex_r.rd == id_rs2_s) && id_rs2_used));
    br_rec_valid_s = (BR_STAGE == BR_MEM) ? mem_r.valid : ex_r.valid;
    taken_s        = br_taken && br_rec_valid_s;
    pc_stall       = load_use_s && !taken_s;
    ifid_stall     = load_use_s && !taken_s;
    idex_bubble    = load_use_s && !taken_s;
    ifid_flush     = taken_s;
    idex_flush     = taken_s;
    exmem_flush    = taken_s && (BR_STAGE == BR_MEM);
  end

  // Next-state records: squashed or bubbled slots become all-zero records
  always_comb begin
    ex_next_s  = '0;
    mem_next_s = '0;
    if (id_valid && !idex_flush && !idex_bubble) begin
      ex_next_s.valid    = 1'b1;
      ex_next_s.rd       = id_rd_s;
      ex_next_s.rs1      = id_rs1_s;
      ex_next_s.rs2      = id_rs2_s;
      ex_next_s.regwrite = id_regwrite;
      ex_next_s.memread  = id_memread;
    end else begin
      ex_next_s = '0;
    end
    if (exmem_flush) begin
      mem_next_s = '0;
    end else begin
      mem_next_s = ex_r;
    end
  end

  // Stage record registers; the pipe advances every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      ex_r  <= ex_next_s;
      mem_r <= mem_next_s;
      wb_r  <= mem_r;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_stall && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (taken_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  fwd_sel u_fwd_a (
    .ex_valid (ex_r.valid),
    .src      (ex_r.rs1),
    .mem_rec  (mem_r),
    .wb_rec   (wb_r),
    .fwd      (fwd_a)
  );

  fwd_sel u_fwd_b (
    .ex_valid (ex_r.valid),
    .src      (ex_r.rs2),
    .mem_rec  (mem_r),
    .wb_rec   (wb_r),
    .fwd      (fwd_b)
  );

  assign ex_valid  = ex_r.valid;
  assign mem_valid = mem_r.valid;
  assign wb_valid  = wb_r.valid;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule
